frame_rd_streamer: RTL and testbench

Pulls one video/packet frame at a time out of the DDR3 frame buffer's user read port and re-emits it as a valid/ready stream cut into fixed-length packets for the UDP transmit path. It sits in the `rd_clk` domain. It drives `rd_load` and `rd_en`, and consumes `rd_data` and `rd_valid`, which arrive 2 cycles after `rd_en`. A small internal skid FIFO absorbs read latency so that downstream backpressure never drops a word.

---
 rtl/frame_rd_streamer_if.sv | 13 +
 rtl/frame_rd_streamer.sv | 146 ++++++++++++++
 tb/tb_frame_rd_streamer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_rd_streamer_if.sv
// Valid/ready packet stream carrying frame words toward the UDP transmit path.
interface frame_rd_streamer_if #(
    parameter int unsigned DATA_WD = 16
);
    logic [DATA_WD-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/frame_rd_streamer.sv
// Streams one frame from the DDR3 user read port into fixed-length packets,
// with a registered skid FIFO covering the 2-cycle read latency.
module frame_rd_streamer #(
    parameter int unsigned DATA_WD     = 16,
    parameter int unsigned FRAME_WORDS = 518400,
    parameter int unsigned PKT_WORDS   = 512,
    parameter int unsigned LOAD_CYC    = 8,
    parameter int unsigned SKID_DEPTH  = 8
) (
    input  logic                rd_clk,
    input  logic                rst_n,
    input  logic                frame_start,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                start_drop,
    output logic                rd_load,
    output logic                rd_en,
    input  logic                rd_rdy,
    input  logic [DATA_WD-1:0]  rd_data,
    input  logic                rd_valid,
    frame_rd_streamer_if.master m
);
    localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned PW = $clog2(PKT_WORDS);
    localparam int unsigned LW = $clog2(LOAD_CYC);
    localparam int unsigned AW = $clog2(SKID_DEPTH);
    localparam int unsigned OW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned EW = DATA_WD + 2;

    localparam logic [CW-1:0] FrameWords = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] FrameLast  = CW'(FRAME_WORDS - 1);
    localparam logic [PW-1:0] PktLast    = PW'(PKT_WORDS - 1);
    localparam logic [LW-1:0] PhaseLast  = LW'(LOAD_CYC - 1);
    localparam logic [OW-1:0] SkidFull   = OW'(SKID_DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRead, StDrain} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] phase_q;
    logic [CW-1:0] issued_q, recv_q;
    logic [PW-1:0] pkt_q;
    logic [1:0]    inflight_q;
    logic [EW-1:0] mem_q [SKID_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q;
    logic          start_drop_q;

    logic          phase_end, accept, ret, full, pop, push;
    logic          word_first, word_last, room, drained, out_valid;
    logic [EW-1:0] head;

    always_comb begin
        phase_end  = (phase_q == PhaseLast);
        // Returns still in flight when a reset hit belong to no frame.
        accept     = rd_valid && (state_q == StRead || state_q == StDrain);
        ret        = rd_valid && (inflight_q != 2'd0);
        out_valid  = (occ_q != '0);
        full       = (occ_q == SkidFull);
        pop        = out_valid && m.tready;
        push       = accept && (!full || pop);
        word_first = (recv_q == '0);
        word_last  = (pkt_q == PktLast) || (recv_q == FrameLast);
        room       = (32'(occ_q) + 32'(inflight_q) + 32'd1) <= SKID_DEPTH;
        drained    = (recv_q == FrameWords) && (occ_q == '0);
        head       = mem_q[rd_ptr_q];
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StLoad;
            StLoad:   if (phase_end) state_d = StSettle;
            StSettle: if (phase_end) state_d = StRead;
            StRead:   if (issued_q == FrameWords) state_d = StDrain;
            StDrain:  if (drained) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_load    = 1'b0;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        frame_busy = (state_q != StIdle);
        unique case (state_q)
            StLoad:  rd_load = 1'b1;
            StRead:  rd_en = rd_rdy && (issued_q < FrameWords) && room;
            StDrain: frame_done = drained;
            default: ;
        endcase
        start_drop = start_drop_q;
        m.tvalid   = out_valid;
        m.tdata    = out_valid ? head[EW-1:2] : '0;
        m.tlast    = out_valid && head[1];
        m.tuser    = out_valid && head[0];
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            issued_q     <= '0;
            recv_q       <= '0;
            pkt_q        <= '0;
            inflight_q   <= '0;
            start_drop_q <= 1'b0;
        end else begin
            phase_q <= ((state_q == StLoad || state_q == StSettle) && !phase_end) ?
                       phase_q + LW'(1) : '0;
            if ((frame_start && state_q != StIdle) || (accept && !push)) start_drop_q <= 1'b1;
            if (state_q == StIdle && frame_start) begin
                issued_q   <= '0;
                recv_q     <= '0;
                pkt_q      <= '0;
                inflight_q <= '0;
            end else begin
                if (rd_en) issued_q <= issued_q + CW'(1);
                inflight_q <= inflight_q + {1'b0, rd_en} - {1'b0, ret};
                if (accept) begin
                    recv_q <= recv_q + CW'(1);
                    pkt_q  <= word_last ? '0 : pkt_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) mem_q[wr_ptr_q] <= {rd_data, word_last, word_first};
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_frame_rd_streamer.sv
// Scoreboard bench: A streams 20-word frames (8-word packets), B a 16-word exact multiple.
module tb_frame_rd_streamer;
    localparam int FW   = 20;
    localparam int PKT  = 8;
    localparam int SKID = 8;

    logic clk = 1'b0;
    logic rst_n, frame_start, rd_rdy, rd_valid;
    logic [15:0] rd_data;
    logic frame_busy, frame_done, start_drop, rd_load, rd_en;
    logic fs_b, rdy_b, valid_b, busy_b, done_b, drop_b, load_b, en_b;
    logic [15:0] data_b;

    frame_rd_streamer_if #(.DATA_WD(16)) s_a ();
    frame_rd_streamer_if #(.DATA_WD(16)) s_b ();

    frame_rd_streamer #(.DATA_WD(16), .FRAME_WORDS(FW), .PKT_WORDS(PKT), .LOAD_CYC(8),
                        .SKID_DEPTH(SKID)) dut_a (
        .rd_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_busy(frame_busy),
        .frame_done(frame_done), .start_drop(start_drop), .rd_load(rd_load), .rd_en(rd_en),
        .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_valid(rd_valid), .m(s_a));

    frame_rd_streamer #(.DATA_WD(16), .FRAME_WORDS(16), .PKT_WORDS(8), .LOAD_CYC(8),
                        .SKID_DEPTH(8)) dut_b (
        .rd_clk(clk), .rst_n(rst_n), .frame_start(fs_b), .frame_busy(busy_b),
        .frame_done(done_b), .start_drop(drop_b), .rd_load(load_b), .rd_en(en_b),
        .rd_rdy(rdy_b), .rd_data(data_b), .rd_valid(valid_b), .m(s_b));

    initial forever #5 clk = ~clk;

    typedef struct {
        string name;
        int    ready_mode;
        int    gap_at;
        int    busy_at;
        int    exp_words;
        int    exp_lasts;
        int    exp_drop;
    } vec_t;
    vec_t vecs[4];

    int checks = 0, errors = 0;
    int cyc = 0, ready_mode = 0;
    logic cur_rdy = 1'b1;
    logic v0 = 0, v1 = 0, vb0 = 0, vb1 = 0, load_prev = 0, load_prev_b = 0;
    logic [15:0] dd0 = 0, dd1 = 0, db0 = 0, db1 = 0, addr = 0, addr_b = 0;
    logic [7:0] fid = 0;
    logic [17:0] sb[$];
    int exp_k, xfers, lasts, users, done_cnt, done_cyc, final_cyc;
    int en_count, pop_count, rl_cnt, rl_first, en_first;
    int words_b = 0, users_b = 0, done_b_cnt = 0;
    int tl_b[$];
    logic prev_stall = 0;
    int prev_word = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic last_of(input int k);
        return (k % PKT == PKT - 1) || (k == FW - 1);
    endfunction

    // One clock cycle: drive inputs after the falling edge, then observe.
    task automatic step(input logic fs, input logic fsb);
        logic [17:0] e;
        @(negedge clk);
        cyc++;
        frame_start = fs;
        fs_b        = fsb;
        rd_rdy      = cur_rdy;
        s_a.tready  = (ready_mode == 0) || (cyc % 4 == 0);
        rd_valid    = v1;
        rd_data     = dd1;
        if (v1) begin
            sb.push_back({last_of(exp_k), exp_k == 0, dd1});
            exp_k++;
        end
        v1 = v0; dd1 = dd0;
        valid_b = vb1; data_b = db1; vb1 = vb0; db1 = db0;
        #1;
        if (rd_load && !load_prev) addr = 0;
        load_prev = rd_load;
        v0 = rd_en; dd0 = {fid, addr[7:0]};
        if (rd_en) addr++;
        if (load_b && !load_prev_b) addr_b = 0;
        load_prev_b = load_b;
        vb0 = en_b; db0 = addr_b;
        if (en_b) addr_b++;

        if (rd_load) begin
            rl_cnt++;
            if (rl_first < 0) rl_first = cyc;
        end
        if (!rd_rdy) check("en_without_rdy", int'(rd_en), 0);
        if (prev_stall)
            check("stall_hold", int'({s_a.tvalid, s_a.tlast, s_a.tuser, s_a.tdata}), prev_word);
        prev_stall = s_a.tvalid && !s_a.tready;
        prev_word  = int'({1'b1, s_a.tlast, s_a.tuser, s_a.tdata});
        if (s_a.tvalid && s_a.tready) begin
            pop_count++;
            if (sb.size() == 0) check("spurious_word", 1, 0);
            else begin
                e = sb.pop_front();
                check("word", int'({s_a.tlast, s_a.tuser, s_a.tdata}), int'(e));
            end
            if (s_a.tlast) lasts++;
            if (s_a.tuser) users++;
            xfers++;
            if (xfers == FW) final_cyc = cyc;
        end
        if (rd_en) begin
            en_count++;
            if (en_first < 0) en_first = cyc;
            check("occ_bound", int'(en_count - pop_count <= SKID), 1);
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (s_b.tvalid && s_b.tready) begin
            check("b_word", int'(s_b.tdata), words_b);
            if (s_b.tlast) tl_b.push_back(words_b);
            if (s_b.tuser) users_b++;
            words_b++;
        end
        if (done_b) done_b_cnt++;
    endtask

    task automatic clear_counts();
        fid++;
        exp_k = 0; xfers = 0; lasts = 0; users = 0; done_cnt = 0; done_cyc = -1;
        final_cyc = -100; en_count = 0; pop_count = 0; rl_cnt = 0; rl_first = -1;
        en_first = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", int'({rd_load, rd_en, s_a.tvalid, s_a.tlast, s_a.tuser,
              frame_busy, frame_done, start_drop, s_a.tdata}), 0);
        v0 = 0; v1 = 0; vb0 = 0; vb1 = 0;
        sb.delete();
        prev_stall = 0;
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input vec_t v);
        int start, gap_left;
        bit gap_done, busy_done, fs;
        ready_mode = v.ready_mode;
        cur_rdy = 1'b1;
        gap_left = 0; gap_done = 0; busy_done = 0;
        clear_counts();
        check({v.name, "_idle_busy"}, int'(frame_busy), 0);
        step(1'b1, 1'b0);
        start = cyc;
        for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
            fs = 0;
            if (v.gap_at >= 0 && !gap_done && en_count >= v.gap_at) begin
                gap_left = 5;
                gap_done = 1;
            end
            cur_rdy = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            if (v.busy_at >= 0 && !busy_done && xfers >= v.busy_at) begin
                fs = 1;
                busy_done = 1;
            end
            step(fs, 1'b0);
            if (cyc == start + 1) check({v.name, "_busy_rise"}, int'(frame_busy), 1);
        end
        check({v.name, "_done_seen"}, done_cnt, 1);
        step(1'b0, 1'b0);
        check({v.name, "_busy_fall"}, int'(frame_busy), 0);
        step(1'b0, 1'b0);
        check({v.name, "_done_once"}, done_cnt, 1);
        check({v.name, "_done_timing"}, done_cyc - final_cyc, 1);
        check({v.name, "_words"}, xfers, v.exp_words);
        check({v.name, "_lasts"}, lasts, v.exp_lasts);
        check({v.name, "_first_flags"}, users, 1);
        check({v.name, "_start_drop"}, int'(start_drop), v.exp_drop);
        check({v.name, "_sb_empty"}, sb.size(), 0);
        check({v.name, "_load_cycles"}, rl_cnt, 8);
        check({v.name, "_load_start"}, rl_first - start, 1);
        check({v.name, "_first_rd_en"}, en_first - start, 17);
    endtask

    initial begin
        vecs[0] = '{"basic",        0, -1, -1, FW, 3, 0};
        vecs[1] = '{"backpressure", 1, -1, -1, FW, 3, 0};
        vecs[2] = '{"rdy_gap",      0,  4, -1, FW, 3, 0};
        vecs[3] = '{"busy_start",   0, -1, 10, FW, 3, 1};

        frame_start = 0; rd_rdy = 0; rd_valid = 0; rd_data = 0; s_a.tready = 0;
        fs_b = 0; rdy_b = 1; valid_b = 0; data_b = 0; s_b.tready = 1;
        clear_counts();
        do_reset();

        // Exact multiple on instance B: two full packets, no trailing empty one.
        step(1'b0, 1'b1);
        for (int n = 0; n < 300 && done_b_cnt == 0; n++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("b_words", words_b, 16);
        check("b_last_count", tl_b.size(), 2);
        check("b_last0", (tl_b.size() > 0) ? tl_b[0] : -1, 7);
        check("b_last1", (tl_b.size() > 1) ? tl_b[1] : -1, 15);
        check("b_first_flags", users_b, 1);
        check("b_done_once", done_b_cnt, 1);
        check("b_drop", int'(drop_b), 0);
        check("b_busy_fall", int'(busy_b), 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Mid-frame reset at word 12, then a clean full frame.
        ready_mode = 0;
        cur_rdy = 1'b1;
        clear_counts();
        step(1'b1, 1'b0);
        for (int n = 0; n < 300 && xfers < 12; n++) step(1'b0, 1'b0);
        check("reach_word12", xfers, 12);
        do_reset();
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
